gpio_in_conditioner: RTL

GPIO_IN_CONDITIONER -- requirements
Module: gpio_in_conditioner

---
 rtl/gpio_pkg.sv | 20 ++
 rtl/gpio_sync2.sv | 24 ++
 rtl/gpio_in_conditioner.sv | 114 +++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared types and helpers for the GPIO input conditioning path.
// Parity helper zero-extends its operand, so any width up to GPIO_MAX_W works.
package gpio_pkg;

  localparam int GPIO_DATA_W = 16;
  localparam int GPIO_MAX_W  = 64;

  typedef enum logic {
    IDLE     = 1'b0,
    SETTLING = 1'b1
  } gpio_state_t;

  function automatic logic gpio_parity(
    input logic [GPIO_MAX_W-1:0] data,
    input logic                  odd
  );
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/gpio_sync2.sv
// Two-flop synchronizer for raw pad inputs.
// Cleared only by the block reset.
module gpio_sync2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      q     <= '0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/gpio_in_conditioner.sv
// Synchronizes, debounces and parity-tags GPIO pad inputs.
// One shared counter: any restart delays the whole word.
module gpio_in_conditioner
  import gpio_pkg::*;
#(
  parameter int DATA_W          = GPIO_DATA_W,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [DATA_W-1:0] PIN_IN,
  input  logic              PARITYSEL,
  input  logic              PERR_INJ,
  output logic [DATA_W:0]   GPIOIN,
  output logic              CHANGE,
  output logic              STABLE
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DATA_W-1:0] sync2;
  logic [DATA_W-1:0] cand;
  logic [DATA_W-1:0] deb;
  logic [CNT_W-1:0]  cnt;
  logic              change_q;
  logic              differ;
  logic              at_max;
  gpio_state_t       state;
  gpio_state_t       state_nxt;

  gpio_sync2 #(
    .W (DATA_W)
  ) u_sync (
    .clk (HCLK),
    .rst (HRESET),
    .d   (PIN_IN),
    .q   (sync2)
  );

  assign differ = (sync2 != cand);
  assign at_max = (cnt == CNT_MAX);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (sync2 != deb) begin
          state_nxt = SETTLING;
        end
      end
      SETTLING: begin
        if (!differ && at_max) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    STABLE = (state == IDLE);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cand     <= '0;
      deb      <= '0;
      cnt      <= '0;
      change_q <= 1'b0;
    end else begin
      change_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sync2 != deb) begin
            cand <= sync2;
            cnt  <= '0;
          end
        end
        SETTLING: begin
          if (differ) begin
            cand <= sync2;
            cnt  <= '0;
          end else if (at_max) begin
            deb      <= cand;
            change_q <= (cand != deb);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // Parity stays combinational so PARITYSEL acts in the same cycle.
  assign GPIOIN = {
    gpio_parity(GPIO_MAX_W'(deb), PARITYSEL) ^ PERR_INJ,
    deb
  };
  assign CHANGE = change_q;

endmodule
